// File: rtl/dmem_port_arb.sv
// dmem_port_arb: two-requester arbiter for the single data-memory port.
// The ASIP core normally wins the port. The host is forced in after MAX_WAIT
// consecutive refusals. A granted host asserting host_lock takes the port
// over for a back-to-back burst (LOCK state). The issue path is purely
// combinational from the requests and the registered state. Read data
// returns one cycle later and is tagged with the owner that issued it.
module dmem_port_arb #(
  parameter int MEM_W        = 32,
  parameter int DMEMCSW      = 4,
  parameter int SUBDMEMADDRW = 8,
  parameter int MAX_WAIT     = 4
) (
  input  logic                    clk,
  input  logic                    reset_b,
  // core side
  input  logic                    core_req,
  input  logic                    core_rw,
  input  logic [DMEMCSW-1:0]      core_cs,
  input  logic [SUBDMEMADDRW-1:0] core_addr,
  input  logic [MEM_W-1:0]        core_wdat,
  output logic                    core_stall,
  output logic [MEM_W-1:0]        core_rdat,
  output logic                    core_rvalid,
  // host / loader side
  input  logic                    host_req,
  input  logic                    host_rw,
  input  logic [DMEMCSW-1:0]      host_cs,
  input  logic [SUBDMEMADDRW-1:0] host_addr,
  input  logic [MEM_W-1:0]        host_wdat,
  input  logic                    host_lock,
  output logic                    host_gnt,
  output logic [MEM_W-1:0]        host_rdat,
  output logic                    host_rvalid,
  // SRAM port
  output logic                    dmem_rw,
  output logic                    dmem_en_b,
  output logic [DMEMCSW-1:0]      dmem_cs,
  output logic [SUBDMEMADDRW-1:0] dmem_addr,
  output logic [MEM_W-1:0]        dmem_wdat,
  input  logic [MEM_W-1:0]        dmem_rdat,
  // status
  output logic                    host_owns
);

  typedef enum logic [0:0] {
    NORM = 1'b0,  // core has priority
    LOCK = 1'b1   // host owns the port for a burst
  } state_t;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic        rd_pend_reg;   // a read was issued last cycle
  logic        rd_host_reg;   // ...and it belonged to the host
  logic        issue_core;
  logic        issue_host;
  logic        issue_read;

  // Arbitration and next-state logic. Nothing is issued while reset is held
  // so every port output sits at its idle value during reset.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    issue_core    = 1'b0;
    issue_host    = 1'b0;
    if (reset_b) begin
      case (state_reg)
        NORM: begin
          // The host wins when alone, or when it has been refused long enough.
          if (host_req && (!core_req || (wait_cnt_reg >= WAIT_LIMIT))) begin
            issue_host = 1'b1;
          end else if (core_req) begin
            issue_core = 1'b1;
          end
          if (issue_host) begin
            wait_cnt_next = 4'd0;
            if (host_lock) begin
              state_next = LOCK;
            end
          end else if (host_req && (wait_cnt_reg < WAIT_LIMIT)) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
          end
        end
        LOCK: begin
          // The core only sees gaps in the host burst.
          wait_cnt_next = 4'd0;
          if (host_req) begin
            issue_host = 1'b1;
          end else if (core_req) begin
            issue_core = 1'b1;
          end
          if (!host_req || !host_lock) begin
            state_next = NORM;
          end
        end
        default: begin
          state_next    = NORM;
          wait_cnt_next = 4'd0;
        end
      endcase
    end
  end

  // Requester handshakes: stall a core request that was not issued.
  always_comb begin
    core_stall = core_req && reset_b && !issue_core;
    host_gnt   = issue_host;
    host_owns  = (state_reg == LOCK);
  end

  // SRAM port mux; idle port drives zeros with enable and rw high.
  always_comb begin
    dmem_en_b  = 1'b1;
    dmem_rw    = 1'b1;
    dmem_cs    = '0;
    dmem_addr  = '0;
    dmem_wdat  = '0;
    issue_read = 1'b0;
    if (issue_host) begin
      dmem_en_b  = 1'b0;
      dmem_rw    = host_rw;
      dmem_cs    = host_cs;
      dmem_addr  = host_addr;
      dmem_wdat  = host_rw ? '0 : host_wdat;
      issue_read = host_rw;
    end else if (issue_core) begin
      dmem_en_b  = 1'b0;
      dmem_rw    = core_rw;
      dmem_cs    = core_cs;
      dmem_addr  = core_addr;
      dmem_wdat  = core_rw ? '0 : core_wdat;
      issue_read = core_rw;
    end
  end

  // Arbiter state and refusal counter.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_reg    <= NORM;
      wait_cnt_reg <= 4'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Read-return tag: remembers who issued the read in flight.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_pend_reg <= 1'b0;
      rd_host_reg <= 1'b0;
    end else begin
      rd_pend_reg <= issue_read;
      rd_host_reg <= issue_host;
    end
  end

  // Return path: the SRAM data fans out to both requesters, the valid is steered.
  always_comb begin
    core_rdat   = dmem_rdat;
    host_rdat   = dmem_rdat;
    core_rvalid = rd_pend_reg && !rd_host_reg;
    host_rvalid = rd_pend_reg && rd_host_reg;
  end

endmodule

// File: tb/tb_dmem_port_arb.sv
// tb_dmem_port_arb: vector table, directed multi-cycle sequences and a
// randomized run against a rule-level reference model of dmem_port_arb.
module tb_dmem_port_arb;

  localparam int MEM_W = 32;
  localparam int CSW   = 4;
  localparam int AW    = 8;
  localparam int MAXW  = 4;

  logic            clk = 1'b0;
  logic            reset_b;
  logic            core_req, core_rw, core_stall, core_rvalid;
  logic [CSW-1:0]  core_cs;
  logic [AW-1:0]   core_addr;
  logic [31:0]     core_wdat, core_rdat;
  logic            host_req, host_rw, host_lock, host_gnt, host_rvalid;
  logic [CSW-1:0]  host_cs;
  logic [AW-1:0]   host_addr;
  logic [31:0]     host_wdat, host_rdat;
  logic            dmem_rw, dmem_en_b, host_owns;
  logic [CSW-1:0]  dmem_cs;
  logic [AW-1:0]   dmem_addr;
  logic [31:0]     dmem_wdat, dmem_rdat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arb #(
    .MEM_W(MEM_W), .DMEMCSW(CSW), .SUBDMEMADDRW(AW), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .reset_b(reset_b),
    .core_req(core_req), .core_rw(core_rw), .core_cs(core_cs),
    .core_addr(core_addr), .core_wdat(core_wdat), .core_stall(core_stall),
    .core_rdat(core_rdat), .core_rvalid(core_rvalid),
    .host_req(host_req), .host_rw(host_rw), .host_cs(host_cs),
    .host_addr(host_addr), .host_wdat(host_wdat), .host_lock(host_lock),
    .host_gnt(host_gnt), .host_rdat(host_rdat), .host_rvalid(host_rvalid),
    .dmem_rw(dmem_rw), .dmem_en_b(dmem_en_b), .dmem_cs(dmem_cs),
    .dmem_addr(dmem_addr), .dmem_wdat(dmem_wdat), .dmem_rdat(dmem_rdat),
    .host_owns(host_owns)
  );

  // SRAM environment: one-cycle read latency.
  logic [31:0] sram [0:4095];
  always @(posedge clk) begin
    if (dmem_en_b === 1'b0) begin
      if (dmem_rw === 1'b0) sram[{dmem_cs, dmem_addr}] <= dmem_wdat;
      else                  dmem_rdat <= sram[{dmem_cs, dmem_addr}];
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_core(input logic req, input logic rw, input logic [3:0] cs,
                          input logic [7:0] addr, input logic [31:0] wd);
    core_req = req; core_rw = rw; core_cs = cs; core_addr = addr; core_wdat = wd;
  endtask

  task automatic set_host(input logic req, input logic rw, input logic [3:0] cs,
                          input logic [7:0] addr, input logic [31:0] wd, input logic lock);
    host_req = req; host_rw = rw; host_cs = cs; host_addr = addr; host_wdat = wd;
    host_lock = lock;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Everything at its reset value, regardless of what the requesters drive.
  task automatic chk_idle_outputs(input string tag);
    chk({tag, " core_stall"}, 32'(core_stall), 32'd0);
    chk({tag, " host_gnt"},   32'(host_gnt),   32'd0);
    chk({tag, " dmem_en_b"},  32'(dmem_en_b),  32'd1);
    chk({tag, " dmem_rw"},    32'(dmem_rw),    32'd1);
    chk({tag, " dmem_cs"},    32'(dmem_cs),    32'd0);
    chk({tag, " dmem_addr"},  32'(dmem_addr),  32'd0);
    chk({tag, " dmem_wdat"},  dmem_wdat,       32'd0);
    chk({tag, " core_rvalid"}, 32'(core_rvalid), 32'd0);
    chk({tag, " host_rvalid"}, 32'(host_rvalid), 32'd0);
    chk({tag, " host_owns"},  32'(host_owns),  32'd0);
  endtask

  typedef struct {
    logic        creq, crw;
    logic [3:0]  ccs;
    logic [7:0]  caddr;
    logic [31:0] cwd;
    logic        hreq, hrw;
    logic [3:0]  hcs;
    logic [7:0]  haddr;
    logic [31:0] hwd;
    logic        hlock;
    logic        e_stall, e_gnt, e_en_b, e_rw;
    logic [3:0]  e_cs;
    logic [7:0]  e_addr;
    logic [31:0] e_wdat;
    logic        e_crv, e_hrv, e_owns;
    logic [31:0] e_rdat;
  } vec_t;

  vec_t tbl [10];

  // reference-model state for the random phase
  logic [31:0] shadow [int];
  bit          m_locked;
  int          m_ref;

  initial begin
    string       tag;
    int          waited;
    bit          got;
    bit          c_pend, h_pend, c_rw_r, h_rw_r, h_lock_r, prev_lock;
    logic [3:0]  c_cs_r, h_cs_r;
    logic [7:0]  c_addr_r, h_addr_r;
    logic [31:0] c_wd_r, h_wd_r;
    bit          host_wins, core_wins, exp_crv, exp_hrv, exp_known;
    logic [31:0] exp_rd;
    int          idx;

    // inputs                                            expected outputs
    tbl[0] = '{1'b0,1'b0,4'h0,8'h00,32'h0, 1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,
               1'b0,1'b0,1'b1,1'b1,4'h0,8'h00,32'h0,1'b0,1'b0,1'b0,32'h0};
    tbl[1] = '{1'b1,1'b0,4'h1,8'h12,32'hDEADBEEF, 1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,
               1'b0,1'b0,1'b0,1'b0,4'h1,8'h12,32'hDEADBEEF,1'b0,1'b0,1'b0,32'h0};
    tbl[2] = '{1'b1,1'b1,4'h1,8'h12,32'h0, 1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,
               1'b0,1'b0,1'b0,1'b1,4'h1,8'h12,32'h0,1'b0,1'b0,1'b0,32'h0};
    tbl[3] = '{1'b0,1'b0,4'h0,8'h00,32'h0, 1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,
               1'b0,1'b0,1'b1,1'b1,4'h0,8'h00,32'h0,1'b1,1'b0,1'b0,32'hDEADBEEF};
    tbl[4] = '{1'b1,1'b0,4'h1,8'h3F,32'hA5A5A5A5, 1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,
               1'b0,1'b0,1'b0,1'b0,4'h1,8'h3F,32'hA5A5A5A5,1'b0,1'b0,1'b0,32'h0};
    tbl[5] = '{1'b0,1'b0,4'h0,8'h00,32'h0, 1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,
               1'b0,1'b0,1'b1,1'b1,4'h0,8'h00,32'h0,1'b0,1'b0,1'b0,32'h0};
    tbl[6] = '{1'b0,1'b0,4'h0,8'h00,32'h0, 1'b1,1'b0,4'h3,8'h40,32'h0BADF00D,1'b0,
               1'b0,1'b1,1'b0,1'b0,4'h3,8'h40,32'h0BADF00D,1'b0,1'b0,1'b0,32'h0};
    tbl[7] = '{1'b0,1'b0,4'h0,8'h00,32'h0, 1'b1,1'b1,4'h3,8'h40,32'h0,1'b0,
               1'b0,1'b1,1'b0,1'b1,4'h3,8'h40,32'h0,1'b0,1'b0,1'b0,32'h0};
    tbl[8] = '{1'b1,1'b1,4'h1,8'h3F,32'h0, 1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,
               1'b0,1'b0,1'b0,1'b1,4'h1,8'h3F,32'h0,1'b0,1'b1,1'b0,32'h0BADF00D};
    tbl[9] = '{1'b0,1'b0,4'h0,8'h00,32'h0, 1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,
               1'b0,1'b0,1'b1,1'b1,4'h0,8'h00,32'h0,1'b1,1'b0,1'b0,32'hA5A5A5A5};

    // ---------------- reset ----------------
    reset_b = 1'b0;
    set_core(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    set_host(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");
    $display("reset: outputs sampled at reset values");
    tick();
    reset_b = 1'b1;

    // ---------------- vector table ----------------
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      set_core(tbl[i].creq, tbl[i].crw, tbl[i].ccs, tbl[i].caddr, tbl[i].cwd);
      set_host(tbl[i].hreq, tbl[i].hrw, tbl[i].hcs, tbl[i].haddr, tbl[i].hwd, tbl[i].hlock);
      @(negedge clk);
      tag = $sformatf("vec%0d", i);
      chk({tag, " core_stall"}, 32'(core_stall), 32'(tbl[i].e_stall));
      chk({tag, " host_gnt"},   32'(host_gnt),   32'(tbl[i].e_gnt));
      chk({tag, " dmem_en_b"},  32'(dmem_en_b),  32'(tbl[i].e_en_b));
      chk({tag, " dmem_rw"},    32'(dmem_rw),    32'(tbl[i].e_rw));
      chk({tag, " dmem_cs"},    32'(dmem_cs),    32'(tbl[i].e_cs));
      chk({tag, " dmem_addr"},  32'(dmem_addr),  32'(tbl[i].e_addr));
      if (tbl[i].e_en_b || !tbl[i].e_rw)
        chk({tag, " dmem_wdat"}, dmem_wdat, tbl[i].e_wdat);
      chk({tag, " core_rvalid"}, 32'(core_rvalid), 32'(tbl[i].e_crv));
      chk({tag, " host_rvalid"}, 32'(host_rvalid), 32'(tbl[i].e_hrv));
      chk({tag, " host_owns"},  32'(host_owns),  32'(tbl[i].e_owns));
      if (tbl[i].e_crv) chk({tag, " core_rdat"}, core_rdat, tbl[i].e_rdat);
      if (tbl[i].e_hrv) chk({tag, " host_rdat"}, host_rdat, tbl[i].e_rdat);
      $display("vec%0d: creq=%0b hreq=%0b -> en_b=%0b rw=%0b cs=%h addr=%h stall=%0b gnt=%0b crv=%0b hrv=%0b",
               i, tbl[i].creq, tbl[i].hreq, dmem_en_b, dmem_rw, dmem_cs, dmem_addr,
               core_stall, host_gnt, core_rvalid, host_rvalid);
    end

    // ---------------- forced host slot ----------------
    tick();
    set_core(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    set_host(1'b1, 1'b0, 4'h0, 8'h02, 32'h22220002, 1'b0);
    @(negedge clk);
    chk("preload host wr gnt", 32'(host_gnt), 32'd1);
    tick();
    set_core(1'b1, 1'b0, 4'h0, 8'h01, 32'h11110001);
    set_host(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    chk("preload core wr en_b", 32'(dmem_en_b), 32'd0);
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 1; k <= MAXW + 1; k++) begin
        tick();
        set_core(1'b1, 1'b1, 4'h0, 8'h01, 32'h0);
        set_host(1'b1, 1'b1, 4'h0, 8'h02, 32'h0, 1'b0);
        @(negedge clk);
        tag = $sformatf("forced r%0d c%0d", rep, k);
        chk({tag, " host_gnt"},   32'(host_gnt),   32'(k == MAXW + 1));
        chk({tag, " core_stall"}, 32'(core_stall), 32'(k == MAXW + 1));
        chk({tag, " dmem_addr"},  32'(dmem_addr),  (k == MAXW + 1) ? 32'h02 : 32'h01);
        chk({tag, " core_rvalid"}, 32'(core_rvalid), 32'(rep > 0 || k > 1));
        $display("%s: gnt=%0b stall=%0b addr=%h", tag, host_gnt, core_stall, dmem_addr);
      end
      tick();
      set_host(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
      @(negedge clk);
      tag = $sformatf("forced r%0d return", rep);
      chk({tag, " host_rvalid"}, 32'(host_rvalid), 32'd1);
      chk({tag, " core_rvalid"}, 32'(core_rvalid), 32'd0);
      chk({tag, " host_rdat"},   host_rdat,        32'h22220002);
      chk({tag, " core_stall"},  32'(core_stall),  32'd0);
      $display("%s: host_rvalid=%0b rdat=%h", tag, host_rvalid, host_rdat);
    end

    // ---------------- alternating owners, back-to-back reads ----------------
    tick();
    set_core(1'b1, 1'b1, 4'h0, 8'h01, 32'h0);
    set_host(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    chk("alt c1 core_rdat", core_rdat, 32'h11110001);
    chk("alt c1 en_b", 32'(dmem_en_b), 32'd0);
    tick();
    set_core(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    set_host(1'b1, 1'b1, 4'h0, 8'h02, 32'h0, 1'b0);
    @(negedge clk);
    chk("alt c2 host_gnt",    32'(host_gnt),    32'd1);
    chk("alt c2 core_rvalid", 32'(core_rvalid), 32'd1);
    chk("alt c2 host_rvalid", 32'(host_rvalid), 32'd0);
    chk("alt c2 core_rdat",   core_rdat,        32'h11110001);
    tick();
    set_host(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    chk("alt c3 core_rvalid", 32'(core_rvalid), 32'd0);
    chk("alt c3 host_rvalid", 32'(host_rvalid), 32'd1);
    chk("alt c3 host_rdat",   host_rdat,        32'h22220002);
    tick();
    @(negedge clk);
    chk("alt c4 core_rvalid", 32'(core_rvalid), 32'd0);
    chk("alt c4 host_rvalid", 32'(host_rvalid), 32'd0);
    $display("alternating: core then host read returned in order");

    // ---------------- locked host burst ----------------
    waited = 0;
    got = 1'b0;
    while (!got && waited < 10) begin
      tick();
      set_core(1'b1, 1'b1, 4'h1, 8'h12, 32'h0);
      set_host(1'b1, 1'b0, 4'h4, 8'h80, 32'hB0000000, 1'b1);
      @(negedge clk);
      waited++;
      got = host_gnt;
    end
    chk("lock first grant cycle", 32'(waited), 32'(MAXW + 1));
    chk("lock first grant owns", 32'(host_owns), 32'd0);
    chk("lock first grant stall", 32'(core_stall), 32'd1);
    for (int n = 1; n < 8; n++) begin
      tick();
      set_host(1'b1, 1'b0, 4'h4, 8'(8'h80 + n), 32'hB0000000 + 32'(n), (n < 7) ? 1'b1 : 1'b0);
      @(negedge clk);
      tag = $sformatf("burst%0d", n);
      chk({tag, " host_owns"},  32'(host_owns),  32'd1);
      chk({tag, " host_gnt"},   32'(host_gnt),   32'd1);
      chk({tag, " core_stall"}, 32'(core_stall), 32'd1);
      chk({tag, " dmem_addr"},  32'(dmem_addr),  32'h80 + 32'(n));
      chk({tag, " dmem_wdat"},  dmem_wdat,       32'hB0000000 + 32'(n));
      $display("%s: owns=%0b gnt=%0b addr=%h wdat=%h", tag, host_owns, host_gnt, dmem_addr, dmem_wdat);
    end
    tick();
    set_host(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    chk("unlock host_owns",  32'(host_owns),  32'd0);
    chk("unlock core_stall", 32'(core_stall), 32'd0);
    chk("unlock dmem_addr",  32'(dmem_addr),  32'h12);
    tick();
    set_core(1'b1, 1'b1, 4'h4, 8'h87, 32'h0);
    @(negedge clk);
    chk("unlock core_rdat", core_rdat, 32'hDEADBEEF);
    tick();
    set_core(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    @(negedge clk);
    chk("burst readback rvalid", 32'(core_rvalid), 32'd1);
    chk("burst readback rdat",   core_rdat,        32'hB0000007);
    $display("burst: last burst word read back as %h", core_rdat);

    // ---------------- reset with a host read in flight ----------------
    tick();
    set_host(1'b1, 1'b1, 4'h3, 8'h40, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst-inflight issue gnt", 32'(host_gnt), 32'd1);
    tick();
    reset_b = 1'b0;
    set_core(1'b1, 1'b1, 4'h1, 8'h12, 32'h0);
    @(negedge clk);
    chk_idle_outputs("in reset c1");
    tick();
    @(negedge clk);
    chk_idle_outputs("in reset c2");
    tick();
    reset_b = 1'b1;
    set_core(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    set_host(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
    @(negedge clk);
    chk_idle_outputs("after reset c1");
    tick();
    @(negedge clk);
    chk_idle_outputs("after reset c2");
    $display("reset in flight: no stale rvalid after release");

    // ---------------- randomized run against the reference model ----------------
    m_locked = 1'b0; m_ref = 0;
    c_pend = 1'b0; h_pend = 1'b0; prev_lock = 1'b0;
    exp_crv = 1'b0; exp_hrv = 1'b0; exp_known = 1'b0; exp_rd = 32'h0;
    c_rw_r = 1'b0; c_cs_r = 4'h0; c_addr_r = 8'h0; c_wd_r = 32'h0;
    h_rw_r = 1'b0; h_cs_r = 4'h0; h_addr_r = 8'h0; h_wd_r = 32'h0; h_lock_r = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      if (!c_pend && $urandom_range(0, 99) < 55) begin
        c_pend = 1'b1; c_rw_r = 1'($urandom_range(0, 1));
        c_cs_r = 4'($urandom_range(0, 1)); c_addr_r = 8'($urandom_range(0, 7));
        c_wd_r = $urandom;
      end
      if (!h_pend && $urandom_range(0, 99) < (prev_lock ? 85 : 35)) begin
        h_pend = 1'b1; h_rw_r = 1'($urandom_range(0, 1));
        h_cs_r = 4'($urandom_range(0, 1)); h_addr_r = 8'($urandom_range(0, 7));
        h_wd_r = $urandom; h_lock_r = ($urandom_range(0, 2) == 0);
      end
      set_core(c_pend, c_rw_r, c_cs_r, c_addr_r, c_wd_r);
      set_host(h_pend, h_rw_r, h_cs_r, h_addr_r, h_wd_r, h_pend ? h_lock_r : 1'b0);
      @(negedge clk);

      // who gets the port this cycle, straight from the priority rules
      host_wins = h_pend && (m_locked || !c_pend || m_ref >= MAXW);
      core_wins = c_pend && !host_wins;
      tag = $sformatf("rnd%0d", cyc);
      chk({tag, " core_stall"}, 32'(core_stall), 32'(c_pend && !core_wins));
      chk({tag, " host_gnt"},   32'(host_gnt),   32'(host_wins));
      chk({tag, " dmem_en_b"},  32'(dmem_en_b),  32'(!(host_wins || core_wins)));
      chk({tag, " host_owns"},  32'(host_owns),  32'(m_locked));
      chk({tag, " core_rvalid"}, 32'(core_rvalid), 32'(exp_crv));
      chk({tag, " host_rvalid"}, 32'(host_rvalid), 32'(exp_hrv));
      if (exp_known && exp_crv) chk({tag, " core_rdat"}, core_rdat, exp_rd);
      if (exp_known && exp_hrv) chk({tag, " host_rdat"}, host_rdat, exp_rd);
      if (host_wins) begin
        chk({tag, " dmem_rw"},   32'(dmem_rw),   32'(h_rw_r));
        chk({tag, " dmem_cs"},   32'(dmem_cs),   32'(h_cs_r));
        chk({tag, " dmem_addr"}, 32'(dmem_addr), 32'(h_addr_r));
        if (!h_rw_r) chk({tag, " dmem_wdat"}, dmem_wdat, h_wd_r);
      end else if (core_wins) begin
        chk({tag, " dmem_rw"},   32'(dmem_rw),   32'(c_rw_r));
        chk({tag, " dmem_cs"},   32'(dmem_cs),   32'(c_cs_r));
        chk({tag, " dmem_addr"}, 32'(dmem_addr), 32'(c_addr_r));
        if (!c_rw_r) chk({tag, " dmem_wdat"}, dmem_wdat, c_wd_r);
      end else begin
        chk({tag, " idle dmem_rw"},   32'(dmem_rw),   32'd1);
        chk({tag, " idle dmem_addr"}, 32'(dmem_addr), 32'd0);
        chk({tag, " idle dmem_wdat"}, dmem_wdat,      32'd0);
      end

      // memory effect and read return for next cycle
      exp_crv = 1'b0; exp_hrv = 1'b0; exp_known = 1'b0;
      if (host_wins || core_wins) begin
        idx = host_wins ? int'({h_cs_r, h_addr_r}) : int'({c_cs_r, c_addr_r});
        if (host_wins ? !h_rw_r : !c_rw_r) begin
          shadow[idx] = host_wins ? h_wd_r : c_wd_r;
        end else begin
          exp_crv = core_wins; exp_hrv = host_wins;
          exp_known = shadow.exists(idx);
          exp_rd = exp_known ? shadow[idx] : 32'h0;
        end
        $display("rnd%0d: %s %s cs=%0d addr=%0d owns=%0b", cyc, host_wins ? "host" : "core",
                 (host_wins ? h_rw_r : c_rw_r) ? "rd" : "wr",
                 host_wins ? h_cs_r : c_cs_r, host_wins ? h_addr_r : c_addr_r, m_locked);
      end

      // refusal count and ownership for the next cycle
      if (host_wins || m_locked) m_ref = 0;
      else if (h_pend && m_ref < MAXW) m_ref = m_ref + 1;
      m_locked = m_locked ? (h_pend && h_lock_r) : (host_wins && h_lock_r);
      prev_lock = host_wins && h_lock_r;
      if (core_wins) c_pend = 1'b0;
      if (host_wins) h_pend = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
